// File: rtl/cpu_out_sink.sv
`default_nettype none
// ============================================================================
// Module   : cpu_out_sink
// Purpose  : Drives the CPU run switch (startIO), captures flagged CPU output
//            words into a show-ahead FIFO and streams them on ready/valid.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_out_sink #(
    parameter int WIDTH    = 36,
    parameter int DEPTH    = 8,
    parameter int CNTWIDTH = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                outFlag,
    input  logic [WIDTH-1:0]    out,
    output logic                startIO,
    output logic                m_valid,
    output logic [WIDTH-1:0]    m_data,
    input  logic                m_ready,
    output logic                overflow,
    output logic [CNTWIDTH-1:0] word_count,
    output logic [CNTWIDTH-1:0] drop_count,
    output logic                done
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] c_FULL     = OW'(DEPTH);
    localparam logic [OW-1:0] c_THROTTLE = OW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q;
    logic                flag_q;
    logic [OW-1:0]       occ_q, occ_d;
    logic [AW-1:0]       rd_q, rd_d;
    logic [AW-1:0]       wr_q;
    logic [WIDTH-1:0]    mem [DEPTH];
    logic [WIDTH-1:0]    data_q, data_d;
    logic                valid_q;
    logic                start_q;
    logic                done_q;
    logic                ovf_q;
    logic [CNTWIDTH-1:0] wcnt_q;
    logic [CNTWIDTH-1:0] dcnt_q;

    logic w_cap, w_pop, w_push, w_drop, w_empty_after_pop;

    assign w_cap  = outFlag & ~flag_q;
    assign w_pop  = valid_q & m_ready;
    assign w_push = w_cap & ((occ_q != c_FULL) | w_pop);
    assign w_drop = w_cap & ~w_push;
    assign w_empty_after_pop = ((occ_q - OW'(w_pop)) == '0);

    // The head register is loaded with whatever word will be at the head next
    // cycle; a push into an otherwise-empty FIFO goes straight there.
    always_comb begin
        occ_d  = occ_q + OW'(w_push) - OW'(w_pop);
        rd_d   = rd_q + AW'(w_pop);
        data_d = data_q;
        if (occ_d != '0) begin
            if (w_push && w_empty_after_pop) begin
                data_d = out;
            end else begin
                data_d = mem[rd_d];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            mem[wr_q] <= out;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flag_q  <= 1'b1;
            occ_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            wcnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            flag_q  <= outFlag;
            occ_q   <= occ_d;
            rd_q    <= rd_d;
            wr_q    <= wr_q + AW'(w_push);
            data_q  <= data_d;
            valid_q <= (occ_d != '0);
            if (w_push) begin
                wcnt_q <= wcnt_q + 1'b1;
            end
            if (w_drop) begin
                ovf_q <= 1'b1;
                if (dcnt_q != '1) begin
                    dcnt_q <= dcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Throttle one slot early so a word already in flight fits.
                    start_q <= (occ_q < c_THROTTLE);
                    if (!enable) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (enable) begin
                        state_q <= RUN;
                    end else if ((occ_q == '0) && !w_cap) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign startIO    = start_q;
    assign m_valid    = valid_q;
    assign m_data     = data_q;
    assign overflow   = ovf_q;
    assign word_count = wcnt_q;
    assign drop_count = dcnt_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_out_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_out_sink
// Purpose  : Scoreboard bench for cpu_out_sink with a queue-based FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_out_sink;

    localparam int WIDTH = 36;
    localparam int DEPTH = 8;
    localparam int CW    = 16;

    logic             clock   = 1'b0;
    logic             reset   = 1'b0;
    logic             enable  = 1'b0;
    logic             outFlag = 1'b0;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] out     = '0;
    logic             startIO, m_valid, overflow, done;
    logic [WIDTH-1:0] m_data;
    logic [CW-1:0]    word_count, drop_count;

    cpu_out_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTWIDTH(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .outFlag    (outFlag),
        .out        (out),
        .startIO    (startIO),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .overflow   (overflow),
        .word_count (word_count),
        .drop_count (drop_count),
        .done       (done)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state: expected stream contents and bookkeeping.
    logic [WIDTH-1:0] exp_q[$];
    int               occ       = 0;
    logic             prev_flag = 1'b1;
    logic [CW-1:0]    mwc       = '0;
    logic [CW-1:0]    mdc       = '0;
    logic             movf      = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_startIO"},    startIO,    0);
        check({tag, "_m_valid"},    m_valid,    0);
        check({tag, "_m_data"},     m_data,     0);
        check({tag, "_overflow"},   overflow,   0);
        check({tag, "_word_count"}, word_count, 0);
        check({tag, "_drop_count"}, drop_count, 0);
        check({tag, "_done"},       done,       0);
    endtask

    task automatic pulse(input logic [WIDTH-1:0] w);
        out     = w;
        outFlag = 1'b1;
        tick();
        outFlag = 1'b0;
        tick();
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[WIDTH-1:0];
    endfunction

    // Model: rising-edge capture into a bounded queue, pop on ready when non-empty.
    initial begin : model
        bit cap, pop, acc;
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                exp_q.delete();
                occ       = 0;
                prev_flag = 1'b1;
                mwc       = '0;
                mdc       = '0;
                movf      = 1'b0;
            end else begin
                cap = outFlag && !prev_flag;
                pop = (occ > 0) && m_ready;
                acc = cap && ((occ < DEPTH) || pop);
                if (pop) occ--;
                if (acc) begin
                    occ++;
                    exp_q.push_back(out);
                    mwc++;
                end else if (cap) begin
                    movf = 1'b1;
                    if (mdc != '1) mdc++;
                end
                prev_flag = outFlag;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (reset) begin
                check("m_valid", m_valid, occ > 0);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word actual=%0h required=none", m_data);
                    end else begin
                        check("m_data", m_data, exp_q.pop_front());
                    end
                end
                check("word_count", word_count, mwc);
                check("drop_count", drop_count, mdc);
                check("overflow",   overflow,   movf);
            end
        end
    end

    initial begin : stim
        int dones;
        // Reset with outFlag already high: release must not capture.
        outFlag = 1'b1;
        enable  = 1'b1;
        #1;
        check_reset_outputs("rst");
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("startIO_after_1", startIO, 0);
        tick();
        check("startIO_after_2", startIO, 1);
        check("no_capture_wc", word_count, 0);
        outFlag = 1'b0;
        tick();

        // Three words, each flagged for three cycles.
        m_ready = 1'b1;
        foreach (dut.mem[i]) begin end
        out = 36'h000000001; outFlag = 1'b1; repeat (3) tick(); outFlag = 1'b0; tick();
        out = 36'h0ABCDEF01; outFlag = 1'b1; repeat (3) tick(); outFlag = 1'b0; tick();
        out = 36'hFFFFFFFFF; outFlag = 1'b1; repeat (3) tick(); outFlag = 1'b0; tick();
        repeat (3) tick();
        check("three_words_wc", word_count, 3);
        check("three_words_out", exp_q.size(), 0);

        // Fill with no consumer: throttle, last slot, then drops.
        m_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            pulse(rand_word());
            if (i == 6) check("startIO_occ6", startIO, 1);
            if (i == 7) check("startIO_occ7", startIO, 0);
            if (i == 8) check("drop_none_at8", drop_count, 0);
        end
        check("ovf_set", overflow, 1);
        check("drop_two", drop_count, 2);
        check("wc_after_fill", word_count, 11);

        // Full FIFO, capture and pop in the same cycle.
        out     = rand_word();
        outFlag = 1'b1;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        outFlag = 1'b0;
        tick();
        check("full_pushpop_drop", drop_count, 2);
        check("full_pushpop_wc", word_count, 12);
        pulse(rand_word());
        check("still_full_drop", drop_count, 3);

        // Leave three words, then drop enable and drain.
        m_ready = 1'b1;
        repeat (5) tick();
        m_ready = 1'b0;
        enable  = 1'b0;
        tick();
        tick();
        check("drain_startIO", startIO, 0);
        m_ready = 1'b1;
        dones   = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) dones++;
        end
        check("done_once", dones, 1);
        check("drained_valid", m_valid, 0);
        check("idle_startIO", startIO, 0);

        // Randomized traffic with an asynchronous reset mid-burst.
        enable = 1'b1;
        for (int n = 0; n < 600; n++) begin
            m_ready = ((n % 200) < 100) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            if (!outFlag) begin
                if ($urandom % 2) begin
                    out     = rand_word();
                    outFlag = 1'b1;
                end
            end else if (($urandom % 3) == 0) begin
                outFlag = 1'b0;
            end
            if ((n % 150) == 140) enable = 1'b0;
            if ((n % 150) == 0)   enable = 1'b1;
            if (n == 300) begin
                #1 reset = 1'b0;
                #1 check_reset_outputs("async");
                tick();
                tick();
                reset = 1'b1;
            end
            tick();
        end

        outFlag = 1'b0;
        m_ready = 1'b1;
        repeat (20) tick();
        check("final_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
